// File: rtl/alu_operand_mux.sv
// Purpose : registered N:1 ALU B-operand select (sources or extended immediate) with a skid buffer.
// Latency : 1 cycle; a beat accepted on edge n is presented on out_* right after edge n.
// Backpress: absorbs at most two beats (OUT + SKID); in_ready is a flop output that drops while SKID is full.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data             NUM_IN packed sources, source k at [k*WIDTH +: WIDTH]
//   imm, imm_sext       immediate field and its extension mode (1 = sign, 0 = zero)
//   sel                 0..NUM_IN-1 source, NUM_IN immediate, anything above is illegal
//   in_valid/in_ready   upstream handshake
//   out_data/out_err    selected operand and illegal-select flag
//   out_valid/out_ready downstream handshake
module alu_operand_mux #(
    parameter int WIDTH     = 16,
    parameter int NUM_IN    = 4,
    parameter int IMM_WIDTH = 8,
    parameter int SEL_W     = $clog2(NUM_IN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [IMM_WIDTH-1:0]    imm,
    input  logic                    imm_sext,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // State encoding is {SKID.valid, OUT.valid}, so the valid bits are the state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             skid_err_q, skid_err_d;

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sel_dat;
    logic             sel_err;
    logic             accept;
    logic             drain;

    // A zero-width replication is illegal, so the full-width immediate gets its own branch.
    generate
        if (IMM_WIDTH == WIDTH) begin : g_imm_full
            assign imm_ext = imm;
        end else begin : g_imm_ext
            assign imm_ext = {{(WIDTH-IMM_WIDTH){imm_sext & imm[IMM_WIDTH-1]}}, imm};
        end
    endgenerate

    // Operand select for the beat currently offered upstream.
    always_comb begin
        sel_dat = '0;
        sel_err = 1'b0;
        if (sel == SEL_W'(NUM_IN)) begin
            sel_dat = imm_ext;
        end else if (sel > SEL_W'(NUM_IN)) begin
            sel_err = 1'b1;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (sel == SEL_W'(k)) begin
                    sel_dat = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // in_ready and out_valid come straight from state flops: no combinational
    // path from in_valid/out_ready reaches either of them.
    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = ONE;
            end
            ONE: begin
                if (accept && !drain)      state_d = FULL;
                else if (!accept && drain) state_d = EMPTY;
            end
            FULL: begin
                // in_ready is low here, so nothing is accepted while SKID drains.
                if (drain) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath next values: OUT only changes on load, so it holds while stalled.
    always_comb begin
        out_dat_d  = out_dat_q;
        out_err_d  = out_err_q;
        skid_dat_d = skid_dat_q;
        skid_err_d = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_dat_d = sel_dat;
                    out_err_d = sel_err;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_dat_d = sel_dat;
                    out_err_d = sel_err;
                end else if (accept) begin
                    skid_dat_d = sel_dat;
                    skid_err_d = sel_err;
                end
            end
            FULL: begin
                if (drain) begin
                    out_dat_d  = skid_dat_q;
                    out_err_d  = skid_err_q;
                    skid_dat_d = '0;
                    skid_err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dat_q  <= '0;
            out_err_q  <= 1'b0;
            skid_dat_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            out_dat_q  <= out_dat_d;
            out_err_q  <= out_err_d;
            skid_dat_q <= skid_dat_d;
            skid_err_q <= skid_err_d;
        end
    end

    // Output drive.
    always_comb begin
        out_data = out_dat_q;
        out_err  = out_err_q;
    end

endmodule

// File: doc/alu_operand_mux.md
# alu_operand_mux

Registered, parametrised N:1 operand-select stage for the ALU B-operand path. It chooses one of NUM_IN register-file/forwarding sources or a sign- or zero-extended immediate, and presents the result through a valid/ready handshake. A one-entry skid buffer lets `in_ready` be a pure register output, so the stage can sit between decode and execute without a combinational ready path.

## Interface
- WIDTH, 16, operand width in bits
- NUM_IN, 4, number of register/forwarding data sources (≥2)
- IMM_WIDTH, 8, immediate field width (1 ≤ IMM_WIDTH ≤ WIDTH)
- SEL_W, $clog2(NUM_IN+1), select width (derived; not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_data  input  NUM_IN*WIDTH  packed sources; source k at [k*WIDTH +: WIDTH]
- imm  input  IMM_WIDTH  immediate field
- imm_sext  input  1  1 = sign-extend imm, 0 = zero-extend
- sel  input  SEL_W  0..NUM_IN-1 pick source; NUM_IN picks extended imm; >NUM_IN illegal
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept (registered)
- out_data  output  WIDTH  selected operand
- out_err  output  1  beat carried an illegal sel
- out_valid  output  1  out_data/out_err valid
- out_ready  input  1  downstream accepts

## Operation
- Select function, computed on the accepted beat: source k, ext(imm), or 0 with err=1 for sel > NUM_IN.
- ext(imm): sext copies imm[IMM_WIDTH-1] into the upper WIDTH-IMM_WIDTH bits; zext fills them with 0. When IMM_WIDTH == WIDTH, imm passes unchanged.
- Storage: output register (OUT) plus skid register (SKID), each holding {data, err, valid}.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- States, encoded by {SKID.valid, OUT.valid}:
  - EMPTY (0,0): accept → OUT; go to ONE.
  - ONE (0,1):
    - accept & drain → OUT reloads; stay in ONE.
    - accept & !drain → beat goes to SKID; go to FULL.
    - !accept & drain → EMPTY.
  - FULL (1,1): in_ready = 0. Drain → SKID moves to OUT, SKID clears; go to ONE. A new beat is never accepted in the cycle SKID drains.
- in_ready = !SKID.valid, registered.
- Order is preserved. No beat is dropped or duplicated.
- out_data/out_err stay stable while out_valid & !out_ready.
- in_data/imm/sel are sampled only on accept. Values are don't-care otherwise.
- Reset (async, any state, mid-transfer included) discards OUT and SKID contents.
- Reset values: out_valid=0, out_data=0, out_err=0, in_ready=1, SKID cleared.

## Timing
- Latency: a beat accepted at edge n is visible on out_valid/out_data after edge n.
- Throughput: 1 beat/cycle while out_ready is held high.
- Backpressure: with out_ready low, at most 2 beats are absorbed (OUT + SKID). in_ready falls after the edge that fills SKID.
- in_ready returns high after the edge on which FULL drains.
- Reset assertion clears all state immediately, without waiting for clk. The first accept is possible on the first edge after rst deasserts.
- No combinational path from in_valid/out_ready to in_ready or out_valid.

## Test plan
- Reset/idle: assert rst mid-stream with OUT and SKID full → out_valid=0, out_data=0, out_err=0, in_ready=1 immediately, before any clock edge.
- Source select, WIDTH=16, NUM_IN=4, out_ready=1: sources 0x1111/0x2222/0x3333/0x4444, sel=0..3 on consecutive cycles → out_data 0x1111, 0x2222, 0x3333, 0x4444 one cycle after each, back-to-back.
- Immediate extension: imm=0x85, sel=4, imm_sext=1 → 0xFF85, out_err=0. Same with imm_sext=0 → 0x0085. imm=0x7F with imm_sext=1 → 0x007F.
- Illegal select: sel=5 → out_data=0x0000, out_err=1. Next beat with sel=1 → out_err=0.
- Backpressure/skid: out_ready=0, send beats A=0xAAAA and B=0xBBBB → in_ready=0 after B is accepted, out_data holds 0xAAAA. Raise out_ready → A then B on consecutive cycles, in_ready=1 the cycle after the FULL drain, no loss or reorder.
- Random stress: random in_valid/out_ready over 10k cycles against a scoreboard queue → exact in-order match, and out_data stable whenever out_valid & !out_ready.
